loop_ctrl_seq: RTL and testbench

LOOP_CTRL_SEQ -- requirements
Module: loop_ctrl_seq

---
 rtl/loop_ctrl_seq.sv | 110 +++++++++++
 tb/tb_loop_ctrl_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/loop_ctrl_seq.sv
// Loop bring-up sequencer: precharge, VCO settle, lock acquisition with timeout,
// lock monitoring and fault hold. Moore outputs decoded from the state register.
module loop_ctrl_seq #(
    parameter int unsigned PRE_CYC    = 16,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned LOCK_N     = 8,
    parameter int unsigned TMO_CYC    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       CELV,
    input  logic       CELG,
    input  logic       SUB,
    input  logic       en,
    input  logic       lock_in,
    input  logic       retry,
    output logic       pd_n,
    output logic       vco_en,
    output logic       cp_en,
    output logic       loop_rdy,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        PRE   = 3'd1,
        VCO   = 3'd2,
        ACQ   = 3'd3,
        LOCK  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [15:0] PRE_END = 16'(PRE_CYC - 1);
    localparam logic [15:0] VCO_END = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TMO_END = 16'(TMO_CYC - 1);
    localparam logic [7:0]  RUN_END = 8'(LOCK_N - 1);

    state_t      cur;
    state_t      nxt;
    logic        sync1;
    logic        lock_s;
    logic [15:0] cnt;
    logic [7:0]  run;
    logic        unused_ties;

    assign unused_ties = ^{CELV, CELG, SUB};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= lock_in;
            lock_s <= sync1;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            OFF:   nxt = PRE;
            PRE:   if (cnt == PRE_END) nxt = VCO;
            VCO:   if (cnt == VCO_END) nxt = ACQ;
            // lock is tested first so it wins a coincident timeout
            ACQ: begin
                if (lock_s && run == RUN_END)
                    nxt = LOCK;
                else if (cnt == TMO_END)
                    nxt = FAULT;
            end
            LOCK:  if (!lock_s && run == RUN_END) nxt = ACQ;
            FAULT: if (retry) nxt = PRE;
            default: nxt = OFF;
        endcase
        if (!en)
            nxt = OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= OFF;
            cnt <= '0;
            run <= '0;
        end else begin
            cur <= nxt;
            // any state entry (including LOCK -> ACQ) restarts both counters
            if (nxt != cur || nxt == OFF) begin
                cnt <= '0;
                run <= '0;
            end else begin
                if (cnt != '1)
                    cnt <= cnt + 16'd1;
                case (cur)
                    ACQ:     run <= lock_s  ? ((run != '1) ? run + 8'd1 : run) : '0;
                    LOCK:    run <= !lock_s ? ((run != '1) ? run + 8'd1 : run) : '0;
                    default: run <= '0;
                endcase
            end
        end
    end

    assign pd_n     = (cur == PRE) || (cur == VCO) || (cur == ACQ) || (cur == LOCK);
    assign vco_en   = (cur == VCO) || (cur == ACQ) || (cur == LOCK);
    assign cp_en    = (cur == ACQ) || (cur == LOCK);
    assign loop_rdy = (cur == LOCK);
    assign fault    = (cur == FAULT);
    assign state    = cur;

endmodule

// File: tb/tb_loop_ctrl_seq.sv
// Directed bench for loop_ctrl_seq: per-cycle vector table plus hand-written
// async-reset and lock/timeout-coincidence sequences.
module tb_loop_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       lock_in = 1'b0;
    logic       retry = 1'b0;
    logic       pd_n, vco_en, cp_en, loop_rdy, fault;
    logic [2:0] state;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       en;
        logic       lk;
        logic       rt;
        int         n;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    loop_ctrl_seq #(
        .PRE_CYC(4),
        .SETTLE_CYC(8),
        .LOCK_N(3),
        .TMO_CYC(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .CELV(1'b1),
        .CELG(1'b0),
        .SUB(1'b0),
        .en(en),
        .lock_in(lock_in),
        .retry(retry),
        .pd_n(pd_n),
        .vco_en(vco_en),
        .cp_en(cp_en),
        .loop_rdy(loop_rdy),
        .fault(fault),
        .state(state)
    );

    // expected {pd_n, vco_en, cp_en, loop_rdy, fault} for a state code
    function automatic logic [4:0] exp_out(input logic [2:0] s);
        case (s)
            3'd1:    return 5'b10000;
            3'd2:    return 5'b11000;
            3'd3:    return 5'b11100;
            3'd4:    return 5'b11110;
            3'd5:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic check(input string name, input logic [2:0] xs);
        logic [7:0] act, req;
        act = {state, pd_n, vco_en, cp_en, loop_rdy, fault};
        req = {xs, exp_out(xs)};
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got state/outs %b, required %b", name, $time, act, req);
        end
    endtask

    task automatic step(input logic e, input logic l, input logic r,
                        input logic [2:0] xs, input string name);
        en = e;
        lock_in = l;
        retry = r;
        @(posedge clk);
        #1;
        check(name, xs);
    endtask

    initial begin
        // nominal start and loss-of-lock tolerance
        tbl.push_back('{1'b0, 1'b0, 1'b0, 2,  3'd0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4,  3'd1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8,  3'd2});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 3,  3'd3});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 5,  3'd4});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  3'd4});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4,  3'd4});
        // three-cycle drop: back to ACQ, then timeout and retry
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4,  3'd4});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 20, 3'd3});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 3,  3'd5});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1,  3'd1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 3,  3'd1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  3'd2});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 2,  3'd0});
        // retry ignored outside FAULT; disable while in FAULT
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4,  3'd1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8,  3'd2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 20, 3'd3});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 3,  3'd5});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2,  3'd0});

        #12;
        check("reset_hold", 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++)
                step(tbl[i].en, tbl[i].lk, tbl[i].rt, tbl[i].st, $sformatf("vec%0d.%0d", i, c));
        end

        // async reset while in LOCK
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 3'd1, "rst_pre");
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b0, 3'd2, "rst_vco");
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b0, 3'd3, "rst_acq");
        step(1'b1, 1'b1, 1'b0, 3'd4, "rst_lock");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 3'd0);
        @(negedge clk);
        check("reset_held_edge", 3'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_after_reset", 3'd1);

        // coincident lock and timeout: third lock_s sample on ACQ cycle 20
        step(1'b0, 1'b0, 1'b0, 3'd0, "sim_off");
        for (int c = 0; c < 4; c++)  step(1'b1, 1'b0, 1'b0, 3'd1, "sim_pre");
        for (int c = 0; c < 8; c++)  step(1'b1, 1'b0, 1'b0, 3'd2, "sim_vco");
        for (int c = 0; c < 16; c++) step(1'b1, 1'b0, 1'b0, 3'd3, "sim_acq");
        for (int c = 0; c < 4; c++)  step(1'b1, 1'b1, 1'b0, 3'd3, "sim_acq_lk");
        step(1'b1, 1'b1, 1'b0, 3'd4, "sim_lock_wins");
        step(1'b1, 1'b1, 1'b0, 3'd4, "sim_lock_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
